// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator car controller and its scan helper.
package elevator_pkg;

   localparam int LEVELS_DEF        = 8;
   localparam int FLOOR_W_DEF       = 3;
   localparam int TRAVEL_CYCLES_DEF = 4;
   localparam int DOOR_CYCLES_DEF   = 6;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR      = 2'd3
   } state_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

endpackage

// File: rtl/elevator_ctrl_level_scan.sv
// Combinational view of the latched requests relative to the car floor:
// presence at/above/below the car and the collective stop decision for each travel direction.
module level_scan
   import elevator_pkg::*;
#(
   parameter int LEVELS  = LEVELS_DEF,
   parameter int FLOOR_W = FLOOR_W_DEF
) (
   input  logic [LEVELS-1:0]  in_levels,
   input  logic [LEVELS-1:0]  up_levels,
   input  logic [LEVELS-1:0]  down_levels,
   input  logic [FLOOR_W-1:0] floor,
   output logic               at,
   output logic               above,
   output logic               below,
   output logic               stop_up,
   output logic               stop_down
);

   logic [LEVELS-1:0] req_s;

   // Split pending requests around the car and evaluate the stop rules for both directions.
   always_comb begin
      req_s = in_levels | up_levels | down_levels;
      at    = 1'b0;
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < LEVELS; i++) begin
         if (i > int'(floor)) begin
            above = above | req_s[i];
         end else if (i < int'(floor)) begin
            below = below | req_s[i];
         end else begin
            at = req_s[i];
         end
      end
      // An opposite-direction hall call only stops the car when nothing lies further ahead.
      stop_up   = in_levels[floor] | up_levels[floor]   | (down_levels[floor] & ~above);
      stop_down = in_levels[floor] | down_levels[floor] | (up_levels[floor]   & ~below);
   end

endmodule

// File: rtl/elevator_ctrl.sv
// Collective (SCAN) car controller: tracks the floor, times travel and door dwell,
// and returns one-cycle clear pulses for every request it services.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int LEVELS        = LEVELS_DEF,
   parameter int FLOOR_W       = FLOOR_W_DEF,
   parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
   parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LEVELS-1:0]  active_in_levels,
   input  logic [LEVELS-1:0]  active_out_up_levels,
   input  logic [LEVELS-1:0]  active_out_down_levels,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               moving_up,
   output logic               moving_down,
   output logic               door_open,
   output logic [LEVELS-1:0]  clr_in_levels,
   output logic [LEVELS-1:0]  clr_out_up_levels,
   output logic [LEVELS-1:0]  clr_out_down_levels
);

   localparam int TT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DT_W = $clog2(DOOR_CYCLES);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(LEVELS - 1);
   localparam logic [TT_W-1:0]    TRAVEL_LOAD = TT_W'(TRAVEL_CYCLES - 1);
   localparam logic [DT_W-1:0]    DOOR_LOAD   = DT_W'(DOOR_CYCLES - 1);

   state_t             state_r;
   dir_t               dir_r;
   logic [FLOOR_W-1:0] floor_r;
   logic [TT_W-1:0]    travel_timer_r;
   logic [DT_W-1:0]    door_timer_r;
   logic               arrive_r;
   logic               moving_up_r;
   logic               moving_down_r;
   logic               door_open_r;
   logic [LEVELS-1:0]  clr_in_r;
   logic [LEVELS-1:0]  clr_up_r;
   logic [LEVELS-1:0]  clr_down_r;

   logic               at_s;
   logic               above_s;
   logic               below_s;
   logic               stop_up_s;
   logic               stop_down_s;
   logic               svc_s;
   logic               pulse_s;
   logic               reopen_s;
   logic [LEVELS-1:0]  floor_oh_s;
   logic [LEVELS-1:0]  in_here_s;
   logic [LEVELS-1:0]  up_here_s;
   logic [LEVELS-1:0]  down_here_s;
   logic [LEVELS-1:0]  stop_up_clr_s;
   logic [LEVELS-1:0]  stop_down_clr_s;
   logic [LEVELS-1:0]  door_up_clr_s;
   logic [LEVELS-1:0]  door_down_clr_s;

   level_scan #(
      .LEVELS  (LEVELS),
      .FLOOR_W (FLOOR_W)
   ) u_scan (
      .in_levels   (active_in_levels),
      .up_levels   (active_out_up_levels),
      .down_levels (active_out_down_levels),
      .floor       (floor_r),
      .at          (at_s),
      .above       (above_s),
      .below       (below_s),
      .stop_up     (stop_up_s),
      .stop_down   (stop_down_s)
   );

   // Requests at the car floor, the service decision for the current direction and the clear masks.
   always_comb begin
      floor_oh_s  = {{(LEVELS-1){1'b0}}, 1'b1} << floor_r;
      in_here_s   = active_in_levels       & floor_oh_s;
      up_here_s   = active_out_up_levels   & floor_oh_s;
      down_here_s = active_out_down_levels & floor_oh_s;
      // Buttons still show a bit while its clear pulse is out, so those cycles are blind.
      pulse_s     = |{clr_in_r, clr_up_r, clr_down_r};
      if (dir_r == DIR_UP) begin
         svc_s           = at_s & stop_up_s;
         stop_up_clr_s   = up_here_s;
         stop_down_clr_s = down_here_s & {LEVELS{~above_s}};
         door_up_clr_s   = up_here_s;
         door_down_clr_s = {LEVELS{1'b0}};
         reopen_s        = ~pulse_s & (|(in_here_s | up_here_s));
      end else begin
         svc_s           = at_s & stop_down_s;
         stop_up_clr_s   = up_here_s & {LEVELS{~below_s}};
         stop_down_clr_s = down_here_s;
         door_up_clr_s   = {LEVELS{1'b0}};
         door_down_clr_s = down_here_s;
         reopen_s        = ~pulse_s & (|(in_here_s | down_here_s));
      end
   end

   // Car FSM with floor tracking, travel/door timers and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= IDLE;
         dir_r          <= DIR_UP;
         floor_r        <= {FLOOR_W{1'b0}};
         travel_timer_r <= {TT_W{1'b0}};
         door_timer_r   <= {DT_W{1'b0}};
         arrive_r       <= 1'b0;
         moving_up_r    <= 1'b0;
         moving_down_r  <= 1'b0;
         door_open_r    <= 1'b0;
         clr_in_r       <= {LEVELS{1'b0}};
         clr_up_r       <= {LEVELS{1'b0}};
         clr_down_r     <= {LEVELS{1'b0}};
      end else begin
         clr_in_r   <= {LEVELS{1'b0}};
         clr_up_r   <= {LEVELS{1'b0}};
         clr_down_r <= {LEVELS{1'b0}};
         case (state_r)
            IDLE: begin
               if (svc_s) begin
                  state_r      <= DOOR;
                  door_open_r  <= 1'b1;
                  door_timer_r <= DOOR_LOAD;
                  clr_in_r     <= in_here_s;
                  clr_up_r     <= stop_up_clr_s;
                  clr_down_r   <= stop_down_clr_s;
               end else if (above_s && (!below_s || dir_r == DIR_UP)) begin
                  state_r        <= MOVE_UP;
                  dir_r          <= DIR_UP;
                  moving_up_r    <= 1'b1;
                  travel_timer_r <= TRAVEL_LOAD;
                  arrive_r       <= 1'b0;
               end else if (below_s) begin
                  state_r        <= MOVE_DOWN;
                  dir_r          <= DIR_DOWN;
                  moving_down_r  <= 1'b1;
                  travel_timer_r <= TRAVEL_LOAD;
                  arrive_r       <= 1'b0;
               end else begin
                  state_r <= IDLE;
               end
            end
            MOVE_UP: begin
               if (arrive_r && stop_up_s) begin
                  state_r      <= DOOR;
                  moving_up_r  <= 1'b0;
                  door_open_r  <= 1'b1;
                  door_timer_r <= DOOR_LOAD;
                  arrive_r     <= 1'b0;
                  clr_in_r     <= in_here_s;
                  clr_up_r     <= up_here_s;
                  clr_down_r   <= stop_down_clr_s;
               end else if (arrive_r && !above_s) begin
                  state_r     <= IDLE;
                  moving_up_r <= 1'b0;
                  arrive_r    <= 1'b0;
               end else if (travel_timer_r == {TT_W{1'b0}}) begin
                  if (floor_r != TOP_FLOOR) begin
                     floor_r        <= floor_r + 1'b1;
                     travel_timer_r <= TRAVEL_LOAD;
                     arrive_r       <= 1'b1;
                  end else begin
                     state_r     <= IDLE;
                     moving_up_r <= 1'b0;
                     arrive_r    <= 1'b0;
                  end
               end else begin
                  travel_timer_r <= travel_timer_r - 1'b1;
                  arrive_r       <= 1'b0;
               end
            end
            MOVE_DOWN: begin
               if (arrive_r && stop_down_s) begin
                  state_r       <= DOOR;
                  moving_down_r <= 1'b0;
                  door_open_r   <= 1'b1;
                  door_timer_r  <= DOOR_LOAD;
                  arrive_r      <= 1'b0;
                  clr_in_r      <= in_here_s;
                  clr_up_r      <= stop_up_clr_s;
                  clr_down_r    <= down_here_s;
               end else if (arrive_r && !below_s) begin
                  state_r       <= IDLE;
                  moving_down_r <= 1'b0;
                  arrive_r      <= 1'b0;
               end else if (travel_timer_r == {TT_W{1'b0}}) begin
                  if (floor_r != {FLOOR_W{1'b0}}) begin
                     floor_r        <= floor_r - 1'b1;
                     travel_timer_r <= TRAVEL_LOAD;
                     arrive_r       <= 1'b1;
                  end else begin
                     state_r       <= IDLE;
                     moving_down_r <= 1'b0;
                     arrive_r      <= 1'b0;
                  end
               end else begin
                  travel_timer_r <= travel_timer_r - 1'b1;
                  arrive_r       <= 1'b0;
               end
            end
            DOOR: begin
               if (reopen_s) begin
                  door_timer_r <= DOOR_LOAD;
                  clr_in_r     <= in_here_s;
                  clr_up_r     <= door_up_clr_s;
                  clr_down_r   <= door_down_clr_s;
               end else if (door_timer_r == {DT_W{1'b0}}) begin
                  state_r     <= IDLE;
                  door_open_r <= 1'b0;
               end else begin
                  door_timer_r <= door_timer_r - 1'b1;
               end
            end
            default: begin
               state_r       <= IDLE;
               moving_up_r   <= 1'b0;
               moving_down_r <= 1'b0;
               door_open_r   <= 1'b0;
               arrive_r      <= 1'b0;
            end
         endcase
      end
   end

   assign current_floor       = floor_r;
   assign moving_up           = moving_up_r;
   assign moving_down         = moving_down_r;
   assign door_open           = door_open_r;
   assign clr_in_levels       = clr_in_r;
   assign clr_out_up_levels   = clr_up_r;
   assign clr_out_down_levels = clr_down_r;

endmodule
